// File: rtl/key_encoder8_deb.sv
// ============================================================================
// Module   : key_encoder8_deb
// Function : Debounced encoder for 8 active-low keys. It synchronizes the key
//            lines, selects the lowest-index pressed key, and produces
//            debounced press/release pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_encoder8_deb #(
    parameter int DEB_CYCLES = 16,
    parameter int CNT_W      = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] key_n,
    output logic [2:0] code,
    output logic       valid,
    output logic       press,
    output logic       rel,
    output logic       multi
);

    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DEB_P = 2'd1,
        ST_HELD  = 2'd2,
        ST_DEB_R = 2'd3
    } state_t;

    logic [7:0]       r_s1, r_s2;
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_cand, w_cand_nxt;
    logic [2:0]       w_code_nxt;
    logic             w_valid_nxt, w_press_nxt, w_rel_nxt;
    logic             w_raw_any;
    logic [2:0]       w_raw_code;
    logic [7:0]       w_low;
    logic             w_multi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 8'hFF;
            r_s2 <= 8'hFF;
        end else begin
            r_s1 <= key_n;
            r_s2 <= r_s1;
        end
    end

    // Scan downward so the lowest-numbered pressed line wins.
    always_comb begin
        w_raw_code = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!r_s2[i]) begin
                w_raw_code = 3'(i);
            end
        end
    end

    assign w_raw_any = (r_s2 != 8'hFF);
    assign w_low     = ~r_s2;
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign w_multi   = |(w_low & (w_low - 8'd1));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cand_nxt  = r_cand;
        w_code_nxt  = code;
        w_valid_nxt = valid;
        w_press_nxt = 1'b0;
        w_rel_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_raw_any) begin
                    w_cand_nxt  = w_raw_code;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_DEB_P;
                end
            end
            ST_DEB_P: begin
                if (!w_raw_any) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_raw_code != r_cand) begin
                    w_cand_nxt = w_raw_code;
                    w_cnt_nxt  = '0;
                end else if (r_cnt == c_cnt_max) begin
                    w_code_nxt  = r_cand;
                    w_valid_nxt = 1'b1;
                    w_press_nxt = 1'b1;
                    w_state_nxt = ST_HELD;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_HELD: begin
                // Key changes while held are ignored; only a full release matters.
                if (!w_raw_any) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_DEB_R;
                end
            end
            ST_DEB_R: begin
                if (w_raw_any) begin
                    w_state_nxt = ST_HELD;
                end else if (r_cnt == c_cnt_max) begin
                    w_valid_nxt = 1'b0;
                    w_rel_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_cand  <= 3'd0;
            code    <= 3'd0;
            valid   <= 1'b0;
            press   <= 1'b0;
            rel     <= 1'b0;
            multi   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cand  <= w_cand_nxt;
            code    <= w_code_nxt;
            valid   <= w_valid_nxt;
            press   <= w_press_nxt;
            rel     <= w_rel_nxt;
            multi   <= w_multi;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_key_encoder8_deb.sv
// ============================================================================
// Module   : tb_key_encoder8_deb
// Function : Self-checking bench for key_encoder8_deb (DEB_CYCLES = 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_encoder8_deb;

    localparam int c_deb = 4;
    localparam int c_lat = c_deb + 3;

    logic       clk;
    logic       rst_n;
    logic [7:0] key_n;
    logic [2:0] code;
    logic       valid, press, rel, multi;

    key_encoder8_deb #(.DEB_CYCLES(c_deb), .CNT_W(20)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_n),
        .code  (code),
        .valid (valid),
        .press (press),
        .rel   (rel),
        .multi (multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: a two-deep delay line plus a run-length view of keys.
    logic [7:0] m_d1, m_d2;
    int         m_run, m_last;
    bit         m_held;
    logic [2:0] m_code;
    bit         m_valid, m_press, m_rel, m_multi;

    int h_press, h_press_edge, h_rel, h_rel_edge, h_multi_edge;

    typedef struct {
        logic [7:0] key;
        int         hold;
        int         n_press;
        int         exp_code;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_d1 = 8'hFF; m_d2 = 8'hFF;
        m_run = 0; m_last = 8; m_held = 0;
        m_code = 3'd0; m_valid = 0; m_press = 0; m_rel = 0; m_multi = 0;
    endtask

    task automatic model_edge();
        logic [7:0] smp;
        int cls;
        smp  = m_d2;
        m_d2 = m_d1;
        m_d1 = key_n;
        cls  = 8;
        for (int i = 0; i < 8; i++) begin
            if (!smp[i]) begin
                cls = i;
                break;
            end
        end
        if (cls == m_last) m_run++;
        else begin
            m_run  = 1;
            m_last = cls;
        end
        m_multi = ($countones(~smp) >= 2);
        m_press = 0;
        m_rel   = 0;
        if (!m_held && cls != 8 && m_run >= c_deb + 1) begin
            m_held = 1; m_valid = 1; m_press = 1; m_code = 3'(cls);
        end else if (m_held && cls == 8 && m_run >= c_deb + 1) begin
            m_held = 0; m_valid = 0; m_rel = 1;
        end
    endtask

    task automatic tick(input int e);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("model_code",  {29'd0, code},  {29'd0, m_code});
        chk("model_valid", {31'd0, valid}, {31'd0, m_valid});
        chk("model_press", {31'd0, press}, {31'd0, m_press});
        chk("model_rel",   {31'd0, rel},   {31'd0, m_rel});
        chk("model_multi", {31'd0, multi}, {31'd0, m_multi});
        if (press) begin
            h_press++;
            if (h_press_edge < 0) h_press_edge = e;
        end
        if (rel) begin
            h_rel++;
            if (h_rel_edge < 0) h_rel_edge = e;
        end
        if (multi && h_multi_edge < 0) h_multi_edge = e;
    endtask

    task automatic hold(input logic [7:0] k, input int n);
        key_n = k;
        h_press = 0; h_press_edge = -1;
        h_rel = 0; h_rel_edge = -1; h_multi_edge = -1;
        for (int i = 1; i <= n; i++) tick(i);
    endtask

    task automatic reset_pulse(input string tag);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_code"},  {29'd0, code},  32'd0);
        chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
        chk({tag, "_press"}, {31'd0, press}, 32'd0);
        chk({tag, "_rel"},   {31'd0, rel},   32'd0);
        chk({tag, "_multi"}, {31'd0, multi}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{8'hFB, 12, 1, 2};
        vecs[1] = '{8'h5F, 12, 1, 5};
        vecs[2] = '{8'hFE, 10, 1, 0};
        vecs[3] = '{8'h7F, 10, 1, 7};
        vecs[4] = '{8'hEF,  3, 0, 0};
        vecs[5] = '{8'hBF,  9, 1, 6};
        vecs[6] = '{8'h3C, 10, 1, 0};
        vecs[7] = '{8'hFD,  4, 0, 0};
        vecs[8] = '{8'hF7,  8, 1, 3};
        vecs[9] = '{8'h80, 10, 1, 0};

        rst_n = 1'b0;
        key_n = 8'hFF;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_code",  {29'd0, code},  32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_press", {31'd0, press}, 32'd0);
        chk("rst_multi", {31'd0, multi}, 32'd0);
        rst_n = 1'b1;
        hold(8'hFF, 3);

        for (int v = 0; v < 10; v++) begin
            hold(vecs[v].key, vecs[v].hold);
            chk($sformatf("vec%0d_presses", v), h_press, vecs[v].n_press);
            if (vecs[v].n_press > 0) begin
                chk($sformatf("vec%0d_press_edge", v), h_press_edge, c_lat);
                chk($sformatf("vec%0d_code", v), {29'd0, code}, vecs[v].exp_code);
                chk($sformatf("vec%0d_valid", v), {31'd0, valid}, 32'd1);
            end
            if (vecs[v].key == 8'h5F) chk("multi_edge", h_multi_edge, 3);
            hold(8'hFF, 10);
            chk($sformatf("vec%0d_releases", v), h_rel, vecs[v].n_press);
            if (vecs[v].n_press > 0) begin
                chk($sformatf("vec%0d_rel_edge", v), h_rel_edge, c_lat);
                chk($sformatf("vec%0d_code_kept", v), {29'd0, code}, vecs[v].exp_code);
            end
            chk($sformatf("vec%0d_valid_off", v), {31'd0, valid}, 32'd0);
        end

        // Bounce: short FB/FF bursts must never be accepted.
        begin
            int bounce_press;
            bounce_press = 0;
            for (int i = 0; i < 3; i++) begin
                hold(8'hFB, 2); bounce_press += h_press;
                hold(8'hFF, 2); bounce_press += h_press;
            end
            chk("bounce_no_press", bounce_press, 0);
        end
        hold(8'hFB, 10);
        chk("bounce_press_cnt", h_press, 1);
        chk("bounce_press_edge", h_press_edge, c_lat);
        hold(8'hFF, 10);

        // Candidate change during debounce restarts the count.
        hold(8'hFB, 2);
        chk("cand_early_press", h_press, 0);
        hold(8'hF7, 10);
        chk("cand_press_cnt", h_press, 1);
        chk("cand_press_edge", h_press_edge, c_lat);
        chk("cand_code", {29'd0, code}, 32'd3);
        hold(8'hFF, 10);

        // Held change is ignored; short release is a bounce.
        hold(8'hFE, 8);
        chk("held_first_press", h_press, 1);
        hold(8'h7F, 10);
        chk("held_no_repress", h_press, 0);
        chk("held_code_kept", {29'd0, code}, 32'd0);
        hold(8'hFF, 2);
        chk("relb_no_rel1", h_rel, 0);
        hold(8'h7F, 8);
        chk("relb_no_rel2", h_rel, 0);
        chk("relb_valid", {31'd0, valid}, 32'd1);
        hold(8'hFF, 10);
        chk("relb_final_rel", h_rel, 1);

        // Reset in the middle of press debounce, then in the held state.
        hold(8'hF7, 8);
        hold(8'hFF, 10);
        hold(8'hFB, 4);
        reset_pulse("rst_debp");
        hold(8'hFB, 10);
        chk("rst_debp_press_edge", h_press_edge, c_lat);
        chk("rst_debp_code", {29'd0, code}, 32'd2);
        reset_pulse("rst_held");
        hold(8'hFB, 10);
        chk("rst_held_press_edge", h_press_edge, c_lat);
        hold(8'hFF, 10);

        // Random segments against the reference model.
        begin
            logic [7:0] k;
            k = 8'hFF;
            for (int s = 0; s < 200; s++) begin
                case ($urandom_range(0, 3))
                    0: k = 8'hFF;
                    1: k = ~(8'h01 << $urandom_range(0, 7));
                    2: k = 8'($urandom);
                    default: ;
                endcase
                hold(k, $urandom_range(1, 9));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/key_encoder8_deb.md
Name: key_encoder8_deb

Overview:
- Input-side counterpart of the digit-select decoder: takes 8 active-low key/select lines and encodes the pressed line into a 3-bit index.
- The mapping is the exact inverse of the decoder: key_n=8'b11111110 gives code 3'd0, and key_n=8'b01111111 gives code 3'd7.
- Adds a 2-flop synchronizer, lowest-index priority, a debounce state machine and press/release event pulses.
- Sits between board push-buttons and the lab control logic.

Parameters:
- DEB_CYCLES, 16: consecutive stable cycles needed to accept a press or release. Must be >= 2. Use 16 for simulation and about 500000 on the board.
- CNT_W, 20: debounce counter width. Must hold DEB_CYCLES-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- key_n  input  8  raw key lines, active low, asynchronous to clk.
- code  output  3  debounced index of the accepted key.
- valid  output  1  high while the accepted key is held.
- press  output  1  one-cycle pulse when a press is accepted.
- release  output  1  one-cycle pulse when a release is accepted.
- multi  output  1  more than one synchronized line is low.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Sync flops are set to 8'hFF and the state goes to IDLE.
  - cnt, cand, code, valid, press, release and multi are all 0.
  - Takes effect immediately, including mid-debounce. After rst_n rises, the block restarts from IDLE.
- Synchronizer: s1<=key_n, s2<=s1. All logic uses s2 only.
- Combinational terms from s2:
  - raw_any = (s2 != 8'hFF).
  - raw_code = index of the lowest-numbered 0 bit in s2.
- multi is registered every cycle: 1 when two or more bits of s2 are 0.
- press and release default to 0 every cycle and are never high in the same cycle.
- IDLE:
  - If raw_any: cand<=raw_code, cnt<=0, go to DEB_P.
- DEB_P:
  - If !raw_any: go to IDLE.
  - Else if raw_code != cand: cand<=raw_code, cnt<=0.
  - Else if cnt==DEB_CYCLES-1: code<=cand, valid<=1, press<=1, go to HELD.
  - Else: cnt<=cnt+1.
- HELD:
  - If !raw_any: cnt<=0, go to DEB_R.
  - A change of raw_code while any key is low is ignored; code stays latched and no new press is generated.
- DEB_R:
  - If raw_any: go to HELD. This is a bounce: no event, valid stays 1.
  - Else if cnt==DEB_CYCLES-1: valid<=0, release<=1, go to IDLE.
  - Else: cnt<=cnt+1.
- code keeps its last value after release.
- Latency: with key_n stable from just before rising edge E1, press and valid rise after edge E1+DEB_CYCLES+2, i.e. edge 7 with DEB_CYCLES=4. Release has the same latency from key_n returning to 8'hFF.
- A bounce shorter than DEB_CYCLES never produces press or release. Each accepted press produces exactly one press and, later, exactly one release.
- cnt never exceeds DEB_CYCLES-1, so there is no wrap.

Test Plan (DEB_CYCLES=4):
- Clean press: key_n=8'hFB held 20 cycles, then 8'hFF. Required:
  - Single press pulse after edge 7, with code=2 and valid=1.
  - Single release pulse 7 edges after returning to FF, with valid=0 and code staying 2.
- Bounce: toggle key_n FB/FF every 2 cycles for 12 cycles, then hold FB. Required:
  - No press during toggling.
  - Exactly one press 7 edges after the final FB.
- Priority/multi: key_n=8'h5F held. Required: code=5 and press once; multi=1 from edge 3 onward.
- Candidate change: FB for 2 cycles, then F7 held. Required: a single press with code=3, 7 edges after F7 is applied.
- Held change and release bounce:
  - Step 1: hold FE until accepted, then switch to 7F. Required: code stays 0 and no second press.
  - Step 2: drive FF for 2 cycles, then 7F again. Required: no release and valid stays 1.
- Reset mid-operation: assert rst_n=0 during DEB_P and again during HELD. Required:
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After deassert with key_n still low, a fresh press follows 7 edges later.
